// File: rtl/lv_owt_req_ctrl_pkg.sv
// ============================================================================
//  Module   : lv_owt_req_ctrl_pkg
//  Purpose  : Shared types and constants for the OWT register request controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lv_owt_req_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACK       = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_WAIT_RSP  = 3'd4,
        ST_RSP       = 3'd5
    } owt_state_e;

    localparam logic OWT_CMD_WR = 1'b1;
    localparam logic OWT_CMD_RD = 1'b0;

    localparam int RSP_TO_CYC_DEFAULT = 1024;

endpackage

`default_nettype wire

// File: rtl/lv_owt_req_ctrl_if.sv
// ============================================================================
//  Module   : lv_owt_req_ctrl_if
//  Purpose  : Requester-side and OWT encoder/decoder-side signals of the
//             request controller; master = controller, slave = its peers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lv_owt_req_ctrl_if #(
    parameter int REG_AW = 7,
    parameter int REG_DW = 8
);
    logic              i_spi_owt_wr_req;
    logic              i_spi_owt_rd_req;
    logic [REG_AW-1:0] i_spi_owt_addr;
    logic [REG_DW-1:0] i_spi_owt_data;
    logic              o_owt_tx_spi_ack;
    logic              o_owt_rx_spi_rsp;
    logic [REG_DW-1:0] o_owt_rx_spi_rdata;
    logic              o_owt_rsp_err;

    logic              o_owt_tx_req;
    logic              o_owt_tx_cmd;
    logic [REG_AW-1:0] o_owt_tx_addr;
    logic [REG_DW-1:0] o_owt_tx_data;
    logic              i_owt_tx_rdy;
    logic              i_owt_tx_done;

    logic              i_owt_rx_vld;
    logic [REG_AW-1:0] i_owt_rx_addr;
    logic [REG_DW-1:0] i_owt_rx_data;
    logic              i_owt_rx_err;

    logic              o_owt_busy;

    modport master (
        input  i_spi_owt_wr_req, i_spi_owt_rd_req, i_spi_owt_addr, i_spi_owt_data,
        output o_owt_tx_spi_ack, o_owt_rx_spi_rsp, o_owt_rx_spi_rdata, o_owt_rsp_err,
        output o_owt_tx_req, o_owt_tx_cmd, o_owt_tx_addr, o_owt_tx_data,
        input  i_owt_tx_rdy, i_owt_tx_done,
        input  i_owt_rx_vld, i_owt_rx_addr, i_owt_rx_data, i_owt_rx_err,
        output o_owt_busy
    );

    modport slave (
        output i_spi_owt_wr_req, i_spi_owt_rd_req, i_spi_owt_addr, i_spi_owt_data,
        input  o_owt_tx_spi_ack, o_owt_rx_spi_rsp, o_owt_rx_spi_rdata, o_owt_rsp_err,
        input  o_owt_tx_req, o_owt_tx_cmd, o_owt_tx_addr, o_owt_tx_data,
        output i_owt_tx_rdy, i_owt_tx_done,
        output i_owt_rx_vld, i_owt_rx_addr, i_owt_rx_data, i_owt_rx_err,
        input  o_owt_busy
    );

endinterface

`default_nettype wire

// File: rtl/lv_owt_rsp_timer.sv
// ============================================================================
//  Module   : lv_owt_rsp_timer
//  Purpose  : Saturating read-response timeout counter with clear/enable.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lv_owt_rsp_timer
    import lv_owt_req_ctrl_pkg::*;
#(
    parameter int RSP_TO_CYC = RSP_TO_CYC_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = $clog2(RSP_TO_CYC + 1);
    localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(RSP_TO_CYC);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(RSP_TO_CYC - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != C_CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires one count early: the counter reaches RSP_TO_CYC-1 on the same
    // edge that moves the FSM out of WAIT_RSP, so the response pulse lands
    // exactly RSP_TO_CYC cycles after the tx_done cycle.
    assign o_expire = i_en && (cnt_q == C_CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/lv_owt_req_ctrl.sv
// ============================================================================
//  Module   : lv_owt_req_ctrl
//  Purpose  : Turns level read/write register requests into OWT frames and
//             collects the read response. Optional single read retry under
//             macro LV_OWT_REQ_RETRY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lv_owt_req_ctrl
    import lv_owt_req_ctrl_pkg::*;
#(
    parameter int REG_AW     = 7,
    parameter int REG_DW     = 8,
    parameter int RSP_TO_CYC = RSP_TO_CYC_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    lv_owt_req_ctrl_if.master bus
);

    owt_state_e        state_q;
    owt_state_e        state_d;

    logic              cmd_q;
    logic [REG_AW-1:0] addr_q;
    logic [REG_DW-1:0] data_q;

    logic              ack_q;
    logic              tx_req_q;
    logic              busy_q;
    logic              rsp_q;
    logic              err_q;
    logic [REG_DW-1:0] rdata_q;

    logic              w_req;
    logic              w_rsp_good;
    logic              w_fail;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_tmr_expire;

`ifdef LV_OWT_REQ_RETRY_EN
    logic              retry_q;
`endif

    assign w_req      = bus.i_spi_owt_wr_req | bus.i_spi_owt_rd_req;
    assign w_tmr_en   = (state_q == ST_WAIT_RSP);
    assign w_tmr_clr  = (state_q == ST_WAIT_DONE) && bus.i_owt_tx_done;
    assign w_rsp_good = bus.i_owt_rx_vld && !bus.i_owt_rx_err
                        && (bus.i_owt_rx_addr == addr_q);
    // A response in the timeout cycle takes priority over the timeout.
    assign w_fail     = w_tmr_en && (bus.i_owt_rx_vld ? !w_rsp_good : w_tmr_expire);

    lv_owt_rsp_timer #(
        .RSP_TO_CYC (RSP_TO_CYC)
    ) u_rsp_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req) state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.i_owt_tx_rdy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.i_owt_tx_done) begin
                    state_d = (cmd_q == OWT_CMD_WR) ? ST_IDLE : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (w_rsp_good) begin
                    state_d = ST_RSP;
                end else if (w_fail) begin
`ifdef LV_OWT_REQ_RETRY_EN
                    state_d = retry_q ? ST_RSP : ST_SEND;
`else
                    state_d = ST_RSP;
`endif
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= OWT_CMD_RD;
            addr_q   <= '0;
            data_q   <= '0;
            ack_q    <= 1'b0;
            tx_req_q <= 1'b0;
            busy_q   <= 1'b0;
            rsp_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
`ifdef LV_OWT_REQ_RETRY_EN
            retry_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            // Write wins when both requests are raised together.
            if ((state_q == ST_IDLE) && w_req) begin
                cmd_q  <= bus.i_spi_owt_wr_req ? OWT_CMD_WR : OWT_CMD_RD;
                addr_q <= bus.i_spi_owt_addr;
                data_q <= bus.i_spi_owt_data;
            end

            ack_q    <= (state_d == ST_ACK);
            tx_req_q <= (state_d == ST_SEND);
            busy_q   <= (state_d != ST_IDLE);
            rsp_q    <= (state_d == ST_RSP);
            err_q    <= (state_d == ST_RSP) && w_fail;

            if (state_d == ST_RSP) begin
                rdata_q <= w_rsp_good ? bus.i_owt_rx_data : '0;
            end

`ifdef LV_OWT_REQ_RETRY_EN
            if (state_q == ST_IDLE) begin
                retry_q <= 1'b0;
            end else if (w_fail) begin
                retry_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.o_owt_tx_spi_ack   = ack_q;
    assign bus.o_owt_rx_spi_rsp   = rsp_q;
    assign bus.o_owt_rx_spi_rdata = rdata_q;
    assign bus.o_owt_rsp_err      = err_q;
    assign bus.o_owt_tx_req       = tx_req_q;
    assign bus.o_owt_tx_cmd       = cmd_q;
    assign bus.o_owt_tx_addr      = addr_q;
    assign bus.o_owt_tx_data      = data_q;
    assign bus.o_owt_busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_lv_owt_req_ctrl.sv
// ============================================================================
//  Module   : tb_lv_owt_req_ctrl
//  Purpose  : Directed self-checking bench; instance A uses the default
//             timeout, instance B a 16-cycle timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lv_owt_req_ctrl;

    localparam int AW = 7;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel_b;
    logic          wr_req, rd_req;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          tx_rdy, tx_done, rx_vld, rx_err;
    logic [AW-1:0] rx_addr;
    logic [DW-1:0] rx_data;

    int n_cmp = 0;
    int n_err = 0;
    int rsp_cnt_a = 0;
    int rsp_cnt_b = 0;

    always #5 clk = ~clk;

    lv_owt_req_ctrl_if #(.REG_AW(AW), .REG_DW(DW)) if_a ();
    lv_owt_req_ctrl_if #(.REG_AW(AW), .REG_DW(DW)) if_b ();

    lv_owt_req_ctrl #(.REG_AW(AW), .REG_DW(DW)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_a.master)
    );

    lv_owt_req_ctrl #(.REG_AW(AW), .REG_DW(DW), .RSP_TO_CYC(16)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_b.master)
    );

    // Requests go only to the selected instance; encoder/decoder inputs are shared.
    assign if_a.i_spi_owt_wr_req = wr_req & ~sel_b;
    assign if_a.i_spi_owt_rd_req = rd_req & ~sel_b;
    assign if_b.i_spi_owt_wr_req = wr_req & sel_b;
    assign if_b.i_spi_owt_rd_req = rd_req & sel_b;
    assign if_a.i_spi_owt_addr = req_addr;
    assign if_b.i_spi_owt_addr = req_addr;
    assign if_a.i_spi_owt_data = req_data;
    assign if_b.i_spi_owt_data = req_data;
    assign if_a.i_owt_tx_rdy   = tx_rdy;
    assign if_b.i_owt_tx_rdy   = tx_rdy;
    assign if_a.i_owt_tx_done  = tx_done;
    assign if_b.i_owt_tx_done  = tx_done;
    assign if_a.i_owt_rx_vld   = rx_vld;
    assign if_b.i_owt_rx_vld   = rx_vld;
    assign if_a.i_owt_rx_addr  = rx_addr;
    assign if_b.i_owt_rx_addr  = rx_addr;
    assign if_a.i_owt_rx_data  = rx_data;
    assign if_b.i_owt_rx_data  = rx_data;
    assign if_a.i_owt_rx_err   = rx_err;
    assign if_b.i_owt_rx_err   = rx_err;

    wire          w_ack    = sel_b ? if_b.o_owt_tx_spi_ack   : if_a.o_owt_tx_spi_ack;
    wire          w_rsp    = sel_b ? if_b.o_owt_rx_spi_rsp   : if_a.o_owt_rx_spi_rsp;
    wire [DW-1:0] w_rdata  = sel_b ? if_b.o_owt_rx_spi_rdata : if_a.o_owt_rx_spi_rdata;
    wire          w_err    = sel_b ? if_b.o_owt_rsp_err      : if_a.o_owt_rsp_err;
    wire          w_tx_req = sel_b ? if_b.o_owt_tx_req       : if_a.o_owt_tx_req;
    wire          w_tx_cmd = sel_b ? if_b.o_owt_tx_cmd       : if_a.o_owt_tx_cmd;
    wire [AW-1:0] w_tx_adr = sel_b ? if_b.o_owt_tx_addr      : if_a.o_owt_tx_addr;
    wire [DW-1:0] w_tx_dat = sel_b ? if_b.o_owt_tx_data      : if_a.o_owt_tx_data;
    wire          w_busy   = sel_b ? if_b.o_owt_busy         : if_a.o_owt_busy;

    always @(posedge clk) begin
        if (if_a.o_owt_rx_spi_rsp === 1'b1) rsp_cnt_a++;
        if (if_b.o_owt_rx_spi_rsp === 1'b1) rsp_cnt_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req = wr; rd_req = rd; req_addr = a; req_data = d;
        tick();
        chk("ack_latency", 32'(w_ack), 1);
        chk("busy_on_ack", 32'(w_busy), 1);
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    // Called in the ACK cycle with tx_rdy high.
    task automatic send(input bit cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick();
        chk("tx_req", 32'(w_tx_req), 1);
        chk("ack_one_cycle", 32'(w_ack), 0);
        chk("tx_cmd", 32'(w_tx_cmd), 32'(cmd));
        chk("tx_addr", 32'(w_tx_adr), 32'(a));
        chk("tx_data", 32'(w_tx_dat), 32'(d));
        tick();
        chk("tx_req_drop", 32'(w_tx_req), 0);
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic respond(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit e);
        rx_vld = 1'b1; rx_addr = a; rx_data = d; rx_err = e;
        tick();
        rx_vld = 1'b0; rx_err = 1'b0;
    endtask

    task automatic expect_rsp(input logic [DW-1:0] d, input bit e);
        chk("rsp_pulse", 32'(w_rsp), 1);
        chk("rsp_rdata", 32'(w_rdata), 32'(d));
        chk("rsp_err", 32'(w_err), 32'(e));
        tick();
        chk("rsp_end", 32'(w_rsp), 0);
        chk("busy_end", 32'(w_busy), 0);
    endtask

    task automatic bad_read(input logic [AW-1:0] a, input logic [AW-1:0] ra,
                            input logic [DW-1:0] rd, input bit re);
        req(1'b0, 1'b1, a, '0);
        send(1'b0, a, '0);
        done_pulse();
        repeat (3) tick();
        respond(ra, rd, re);
`ifdef LV_OWT_REQ_RETRY_EN
        chk("retry_no_rsp", 32'(w_rsp), 0);
        chk("retry_tx_req", 32'(w_tx_req), 1);
        chk("retry_no_ack", 32'(w_ack), 0);
        chk("retry_addr", 32'(w_tx_adr), 32'(a));
        tick();
        done_pulse();
        repeat (3) tick();
        respond(ra, rd, re);
`endif
        expect_rsp('0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; sel_b = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; req_addr = '0; req_data = '0;
        tx_rdy = 1'b1; tx_done = 1'b0;
        rx_vld = 1'b0; rx_err = 1'b0; rx_addr = '0; rx_data = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(w_busy), 0);
        chk("rst_ack", 32'(w_ack), 0);
        chk("rst_tx_req", 32'(w_tx_req), 0);
        chk("rst_rsp", 32'(w_rsp), 0);
        chk("rst_err", 32'(w_err), 0);
        chk("rst_rdata", 32'(w_rdata), 0);
        chk("rst_b_busy", 32'(if_b.o_owt_busy), 0);
        rst = 1'b0;
        tick();

        // Write 0x08 <- 0x5A, done 20 cycles after accept.
        req(1'b1, 1'b0, 7'h08, 8'h5A);
        send(1'b1, 7'h08, 8'h5A);
        repeat (19) tick();
        chk("wr_busy_before_done", 32'(w_busy), 1);
        done_pulse();
        chk("wr_busy_fall", 32'(w_busy), 0);
        chk("wr_no_rsp", 32'(rsp_cnt_a), 0);

        // Read 0x41 with a two-cycle encoder stall; response 50 cycles after done.
        req(1'b0, 1'b1, 7'h41, 8'h00);
        tx_rdy = 1'b0;
        tick();
        chk("stall_tx_req", 32'(w_tx_req), 1);
        chk("stall_cmd", 32'(w_tx_cmd), 0);
        chk("stall_addr", 32'(w_tx_adr), 32'h41);
        tick();
        chk("stall_hold", 32'(w_tx_req), 1);
        tx_rdy = 1'b1;
        tick();
        chk("stall_accept", 32'(w_tx_req), 0);
        done_pulse();
        repeat (49) tick();
        chk("rd_waiting", 32'(w_rsp), 0);
        respond(7'h41, 8'hC3, 1'b0);
        expect_rsp(8'hC3, 1'b0);
        chk("rdata_hold", 32'(w_rdata), 32'hC3);

        // Bad responses: address mismatch, then decoder error.
        bad_read(7'h14, 7'h15, 8'h66, 1'b0);
        bad_read(7'h14, 7'h14, 8'h77, 1'b1);

        // Simultaneous write and read: write wins; read held off until IDLE.
        req(1'b1, 1'b1, 7'h22, 8'h33);
        send(1'b1, 7'h22, 8'h33);
        rd_req = 1'b1; req_addr = 7'h30; req_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_ack_in_wait_done", 32'(w_ack), 0);
        end
        done_pulse();
        chk("idle_after_wr", 32'(w_busy), 0);
        chk("idle_no_ack", 32'(w_ack), 0);
        tick();
        chk("late_rd_ack", 32'(w_ack), 1);
        rd_req = 1'b0;
        send(1'b0, 7'h30, 8'h00);
        done_pulse();
        repeat (3) tick();
        respond(7'h30, 8'h9E, 1'b0);
        expect_rsp(8'h9E, 1'b0);

        // Reset while waiting for a response.
        req(1'b0, 1'b1, 7'h55, 8'h00);
        send(1'b0, 7'h55, 8'h00);
        done_pulse();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(w_busy), 0);
        chk("mid_rst_rsp", 32'(w_rsp), 0);
        chk("mid_rst_err", 32'(w_err), 0);
        chk("mid_rst_rdata", 32'(w_rdata), 0);
        chk("mid_rst_tx_addr", 32'(w_tx_adr), 0);
        chk("mid_rst_tx_req", 32'(w_tx_req), 0);
        respond(7'h55, 8'hDD, 1'b0);
        chk("late_vld_no_rsp", 32'(w_rsp), 0);
        chk("late_vld_idle", 32'(w_busy), 0);
        req(1'b0, 1'b1, 7'h66, 8'h00);
        send(1'b0, 7'h66, 8'h00);
        done_pulse();
        repeat (2) tick();
        respond(7'h66, 8'hA5, 1'b0);
        expect_rsp(8'hA5, 1'b0);

        // Timeout on instance B (RSP_TO_CYC = 16).
        sel_b = 1'b1;
        req(1'b0, 1'b1, 7'h0C, 8'h00);
        send(1'b0, 7'h0C, 8'h00);
        done_pulse();
        repeat (14) tick();
        chk("to_not_yet", 32'(w_rsp), 0);
        tick();
`ifdef LV_OWT_REQ_RETRY_EN
        chk("to_retry_tx_req", 32'(w_tx_req), 1);
        chk("to_retry_no_rsp", 32'(w_rsp), 0);
        chk("to_retry_no_ack", 32'(w_ack), 0);
        tick();
        done_pulse();
        repeat (14) tick();
        chk("to2_not_yet", 32'(w_rsp), 0);
        tick();
`endif
        expect_rsp(8'h00, 1'b1);
        sel_b = 1'b0;

        chk("rsp_count_a", 32'(rsp_cnt_a), 5);
        chk("rsp_count_b", 32'(rsp_cnt_b), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lv_owt_req_ctrl.md
LV_OWT_REQ_CTRL -- requirements
Module: lv_owt_req_ctrl

Interface
REQ-001 Parameter REG_AW, default 7, register address width.
REQ-002 Parameter REG_DW, default 8, register data width.
REQ-003 Parameter RSP_TO_CYC, default 1024, read-response timeout in i_clk cycles (legal range 2..65535).
REQ-004 Port i_clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 Port i_rst, input, 1, reset: synchronous, active-high.
REQ-006 Port i_spi_owt_wr_req, input, 1, level write request; held until o_owt_tx_spi_ack.
REQ-007 Port i_spi_owt_rd_req, input, 1, level read request; held until o_owt_tx_spi_ack.
REQ-008 Port i_spi_owt_addr, input, REG_AW, request address.
REQ-009 Port i_spi_owt_data, input, REG_DW, write data.
REQ-010 Port o_owt_tx_spi_ack, output, 1, one-cycle request-accepted pulse; also the write completion.
REQ-011 Port o_owt_rx_spi_rsp, output, 1, one-cycle read-completion pulse.
REQ-012 Port o_owt_rx_spi_rdata, output, REG_DW, read data; valid while o_owt_rx_spi_rsp is high.
REQ-013 Port o_owt_rsp_err, output, 1, qualifies o_owt_rx_spi_rsp: the read failed (timeout, CRC error or address mismatch).
REQ-014 Port o_owt_tx_req, input-side handshake to the OWT frame encoder, output, 1, frame-send request.
REQ-015 Port o_owt_tx_cmd, output, 1, 1 = write frame, 0 = read frame.
REQ-016 Ports o_owt_tx_addr (output, REG_AW) and o_owt_tx_data (output, REG_DW), frame fields.
REQ-017 Port i_owt_tx_rdy, input, 1, encoder accepts the frame when o_owt_tx_req and i_owt_tx_rdy are both high.
REQ-018 Port i_owt_tx_done, input, 1, pulse: the last frame bit has been sent.
REQ-019 Ports i_owt_rx_vld (input, 1), i_owt_rx_addr (input, REG_AW), i_owt_rx_data (input, REG_DW) and i_owt_rx_err (input, 1) form the decoded response frame from the OWT decoder.
REQ-020 Port o_owt_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-021 States: IDLE, ACK, SEND, WAIT_DONE, WAIT_RSP, RSP.
- IDLE: a write or read request captures address, data and command, then moves to ACK.
- If write and read requests are both high, the write wins.
REQ-022 ACK lasts one cycle with o_owt_tx_spi_ack=1, then moves to SEND.
- Latency from request high in IDLE to ack is exactly 1 cycle.
- Request inputs are ignored outside IDLE.
REQ-023 SEND holds o_owt_tx_req=1 with stable cmd/addr/data until i_owt_tx_rdy=1, then moves to WAIT_DONE.
REQ-024 WAIT_DONE waits for i_owt_tx_done.
- Write: returns to IDLE.
- Read: clears the timeout counter and moves to WAIT_RSP.
REQ-025 WAIT_RSP increments the timeout counter every cycle; the counter saturates at RSP_TO_CYC.
- Good response: i_owt_rx_vld=1, i_owt_rx_err=0 and i_owt_rx_addr equal to the captured address. Register i_owt_rx_data and go to RSP with err=0.
- Bad response: i_owt_rx_vld=1 with i_owt_rx_err=1 or an address mismatch. Go to RSP with err=1 and rdata=0.
- Timeout: counter reaches RSP_TO_CYC-1 with no response. Go to RSP with err=1 and rdata=0.
- If a response arrives in the same cycle as the timeout, the response wins.
REQ-026 RSP lasts one cycle: o_owt_rx_spi_rsp=1 with rdata and err valid, then returns to IDLE.
REQ-027 i_owt_rx_vld outside WAIT_RSP is dropped and has no effect.
REQ-028 o_owt_rx_spi_rdata holds its last value outside RSP.
- The timeout counter width is $clog2(RSP_TO_CYC+1).

Reset
REQ-029 While i_rst=1 at a clock edge, the next state is IDLE, from any state including mid-frame.
REQ-030 Reset values: counter 0, all outputs 0.
- Any in-flight request is abandoned: no ack or rsp is issued for it.
- The requester re-issues it after reset.

Configuration
REQ-031 With macro LV_OWT_REQ_RETRY_EN defined, a read that fails (timeout or bad response) is re-sent exactly once.
- The FSM returns to SEND with the same fields, no extra ack is issued, and a retry flag is set.
- o_owt_rsp_err is asserted only if the retry also fails.
- Writes are never retried.
REQ-032 With LV_OWT_REQ_RETRY_EN undefined, the first failure goes directly to RSP with err=1, and no retry logic is present.

Structure
REQ-033 The shared lv package holds:
- the state enum typedef;
- the OWT_CMD_WR/OWT_CMD_RD constants;
- the RSP_TO_CYC default.
REQ-034 The timeout counter is a separate sub-module, lv_owt_rsp_timer, with inputs clear and enable and output expire.
- Everything else stays in lv_owt_req_ctrl.

Verification
REQ-035 Write 0x08 data 0x5A, tx_rdy held high, tx_done 20 cycles after accept:
- ack exactly 1 cycle after the request;
- tx_cmd=1, addr=0x08, data=0x5A;
- busy falls the cycle after tx_done;
- no rsp.
REQ-036 Read 0x41, response vld with addr 0x41 and data 0xC3 arriving 50 cycles after tx_done:
- a single rsp pulse with rdata=0xC3 and err=0.
REQ-037 Read 0x0C with no response and RSP_TO_CYC=16:
- rsp with err=1 and rdata=0x00 exactly 16 cycles after tx_done (macro undefined);
- with LV_OWT_REQ_RETRY_EN defined, a second tx_req, then err after the second timeout.
REQ-038 Read 0x14 where the response returns addr 0x15 (and separately rx_err=1):
- rsp with err=1 and rdata=0.
REQ-039 Write and read requested in the same cycle:
- a write frame is sent;
- a read request asserted during WAIT_DONE gets no ack until IDLE.
REQ-040 i_rst pulsed while in WAIT_RSP:
- all outputs are 0 the next cycle;
- a late rx_vld is ignored;
- a new read is then completed normally.
